// File: rtl/player_row_ctrl.sv
// player_row_ctrl: player column tracking from joystick left/right, player row
// rendering as packed colour codes, and shot issue over a valid/ready handshake
// with cooldown and per-shot colour cycling.
// Optional feature macro: PLAYER_AUTOREPEAT_EN (tick-based auto-repeat of a held move).
module player_row_ctrl #(
    parameter int COLS         = 8,
    parameter int DW           = 5,
    parameter int DARK         = 31,
    parameter int COLOR_BASE   = 10,
    parameter int NUM_COLORS   = 3,
    parameter int START_POS    = 1,
    parameter int REPEAT_TICKS = 8,
    parameter int COOLDOWN     = 4,
    localparam int PW          = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic [3:0]           jstkPos,
    input  logic                 shot_ready,
    output logic [COLS*DW-1:0]   PlayerRow,
    output logic [PW-1:0]        player_pos,
    output logic                 shot_valid,
    output logic [PW-1:0]        shot_pos,
    output logic [DW-1:0]        shot_color
);

    localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
    localparam int KW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_COOL
    } shot_state_t;

    logic              w_left_only;
    logic              w_right_only;
    logic              w_fire;
    logic              r_left_only_prev;
    logic              r_right_only_prev;
    logic              r_fire_prev;
    logic              w_left_edge;
    logic              w_right_edge;
    logic              w_fire_edge;
    logic              w_rpt_fire;
    logic              w_step_up;
    logic              w_step_dn;
    logic [PW-1:0]     r_pos;
    logic [PW-1:0]     w_pos_nxt;
    logic [CW-1:0]     r_color_idx;
    logic [CW-1:0]     w_color_idx_nxt;
    logic [COLS*DW-1:0] r_row;
    shot_state_t       r_state;
    shot_state_t       w_state_nxt;
    logic [KW-1:0]     r_cool_cnt;
    logic [KW-1:0]     w_cool_cnt_nxt;
    logic              w_latch;
    logic              w_xfer;
    logic [PW-1:0]     r_shot_pos;
    logic [DW-1:0]     r_shot_color;
    logic              w_unused;

    assign w_unused = &{1'b0, jstkPos[1], REPEAT_TICKS[0]};

    // Edges are taken on the resolved direction, so releasing one of two held
    // buttons is a fresh press of the remaining direction.
    assign w_left_only  = jstkPos[2] & ~jstkPos[3];
    assign w_right_only = jstkPos[3] & ~jstkPos[2];
    assign w_fire       = jstkPos[0];
    assign w_left_edge  = w_left_only  & ~r_left_only_prev;
    assign w_right_edge = w_right_only & ~r_right_only_prev;
    assign w_fire_edge  = w_fire & ~r_fire_prev;

`ifdef PLAYER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [RW-1:0] r_rpt_cnt;

    assign w_rpt_fire = tick && (r_rpt_cnt <= RW'(1));

    // Auto-repeat counter: loaded on a press or repeat move, counts ticks while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt <= '0;
        end else if (en) begin
            if (!(w_left_only || w_right_only)) begin
                r_rpt_cnt <= '0;
            end else if (w_left_edge || w_right_edge || w_rpt_fire) begin
                r_rpt_cnt <= RW'(REPEAT_TICKS);
            end else if (tick) begin
                r_rpt_cnt <= r_rpt_cnt - RW'(1);
            end
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign w_step_up = w_left_only  && (w_left_edge  || w_rpt_fire);
    assign w_step_dn = w_right_only && (w_right_edge || w_rpt_fire);

    // Next position with saturation at both ends.
    always_comb begin
        w_pos_nxt = r_pos;
        if (w_step_up && (r_pos != PW'(COLS - 1))) begin
            w_pos_nxt = r_pos + PW'(1);
        end else if (w_step_dn && (r_pos != '0)) begin
            w_pos_nxt = r_pos - PW'(1);
        end
    end

    assign w_xfer = (r_state == S_PEND) && shot_ready;

    // Colour index advances once per accepted shot.
    always_comb begin
        w_color_idx_nxt = r_color_idx;
        if (w_xfer) begin
            if (r_color_idx == CW'(NUM_COLORS - 1)) begin
                w_color_idx_nxt = '0;
            end else begin
                w_color_idx_nxt = r_color_idx + CW'(1);
            end
        end
    end

    function automatic logic [COLS*DW-1:0] render(input logic [PW-1:0] pos,
                                                 input logic [CW-1:0] cidx);
        logic [COLS*DW-1:0] row;
        row = {COLS{DW'(DARK)}};
        for (int unsigned i = 0; i < COLS; i++) begin
            if (pos == PW'(i)) begin
                row[i*DW +: DW] = DW'(COLOR_BASE) + DW'(cidx);
            end
        end
        return row;
    endfunction

    // Edge history, position, colour and the row image (rendered from next state
    // so it never lags player_pos).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_only_prev  <= 1'b0;
            r_right_only_prev <= 1'b0;
            r_fire_prev       <= 1'b0;
            r_pos             <= PW'(START_POS);
            r_color_idx       <= '0;
            r_row             <= render(PW'(START_POS), '0);
        end else if (en) begin
            r_left_only_prev  <= w_left_only;
            r_right_only_prev <= w_right_only;
            r_fire_prev       <= w_fire;
            r_pos             <= w_pos_nxt;
            r_color_idx       <= w_color_idx_nxt;
            r_row             <= render(w_pos_nxt, w_color_idx_nxt);
        end
    end

    // Shot FSM next-state and outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_cool_cnt_nxt = r_cool_cnt;
        w_latch        = 1'b0;
        shot_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fire_edge) begin
                    w_state_nxt = S_PEND;
                    w_latch     = 1'b1;
                end
            end
            S_PEND: begin
                shot_valid = 1'b1;
                if (shot_ready) begin
                    if (COOLDOWN == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt    = S_COOL;
                        w_cool_cnt_nxt = KW'(COOLDOWN);
                    end
                end
            end
            S_COOL: begin
                if (tick) begin
                    if (r_cool_cnt <= KW'(1)) begin
                        w_state_nxt    = S_IDLE;
                        w_cool_cnt_nxt = '0;
                    end else begin
                        w_cool_cnt_nxt = r_cool_cnt - KW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_cool_cnt_nxt = '0;
            end
        endcase
    end

    // Shot FSM state, cooldown counter and latched shot payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cool_cnt   <= '0;
            r_shot_pos   <= '0;
            r_shot_color <= DW'(COLOR_BASE);
        end else if (en) begin
            r_state    <= w_state_nxt;
            r_cool_cnt <= w_cool_cnt_nxt;
            if (w_latch) begin
                r_shot_pos   <= r_pos;
                r_shot_color <= DW'(COLOR_BASE) + DW'(r_color_idx);
            end
        end
    end

    assign PlayerRow  = r_row;
    assign player_pos = r_pos;
    assign shot_pos   = r_shot_pos;
    assign shot_color = r_shot_color;

endmodule

// File: tb/tb_player_row_ctrl.sv
// tb_player_row_ctrl: directed bench for player_row_ctrl with hand-computed
// expectations; follows PLAYER_AUTOREPEAT_EN for the auto-repeat expectations.
module tb_player_row_ctrl;

    localparam int COLS = 8;
    localparam int DW   = 5;
    localparam int DARK = 31;
    localparam int PW   = $clog2(COLS);

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                tick;
    logic [3:0]          jstk;
    logic                shot_ready;
    logic [COLS*DW-1:0]  PlayerRow;
    logic [PW-1:0]       player_pos;
    logic                shot_valid;
    logic [PW-1:0]       shot_pos;
    logic [DW-1:0]       shot_color;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_p;

    player_row_ctrl #(
        .COLS(8),
        .DW(5),
        .DARK(31),
        .COLOR_BASE(10),
        .NUM_COLORS(3),
        .START_POS(1),
        .REPEAT_TICKS(8),
        .COOLDOWN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .tick(tick),
        .jstkPos(jstk),
        .shot_ready(shot_ready),
        .PlayerRow(PlayerRow),
        .player_pos(player_pos),
        .shot_valid(shot_valid),
        .shot_pos(shot_pos),
        .shot_color(shot_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [COLS*DW-1:0] exp_row(input int pos, input int color);
        logic [COLS*DW-1:0] r;
        for (int i = 0; i < COLS; i++) begin
            r[i*DW +: DW] = (i == pos) ? DW'(color) : DW'(DARK);
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; tick = 1'b0; jstk = 4'b0000; shot_ready = 1'b0;
        step(2);
        check("rst_pos",   player_pos, 1);
        check("rst_row",   PlayerRow, exp_row(1, 10));
        check("rst_valid", shot_valid, 0);
        check("rst_spos",  shot_pos, 0);
        check("rst_scol",  shot_color, 10);
        rst = 1'b0;

        // hold left through 30 ticks
        jstk = 4'b0100;
        step(1);
        check("hold_edge", player_pos, 2);
        for (int t = 1; t <= 30; t++) begin
            pulse_tick();
            if (t == 7 || t == 8 || t == 16 || t == 24 || t == 30) begin
`ifdef PLAYER_AUTOREPEAT_EN
                exp_p = 2 + t / 8;
`else
                exp_p = 2;
`endif
                check($sformatf("hold_t%0d", t), player_pos, exp_p);
            end
        end
        check("hold_row", PlayerRow, exp_row(exp_p, 10));
        jstk = 4'b0000;
        step(1);

        // right presses saturate at column 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            jstk = 4'b1000;
            step(1);
            check($sformatf("right_p%0d", k), player_pos, 0);
            jstk = 4'b0000;
            step(1);
        end
        check("right_row", PlayerRow, exp_row(0, 10));
        check("right_cell0", PlayerRow[4:0], 10);

        // left presses saturate at column 7
        for (int k = 1; k <= 8; k++) begin
            jstk = 4'b0100;
            step(1);
            jstk = 4'b0000;
            step(1);
        end
        check("left_sat", player_pos, 7);
        check("left_row", PlayerRow, exp_row(7, 10));

        // both pressed: no move; releasing right moves left immediately
        do_reset();
        jstk = 4'b1100;
        step(1);
        check("both_1", player_pos, 1);
        step(3);
        check("both_4", player_pos, 1);
        jstk = 4'b0100;
        step(1);
        check("rel_right", player_pos, 2);
        jstk = 4'b0000;
        step(1);

        // fire with consumer stalled, player moves while pending
        do_reset();
        jstk = 4'b0001;
        step(1);
        check("pend_valid", shot_valid, 1);
        check("pend_spos",  shot_pos, 1);
        check("pend_scol",  shot_color, 10);
        jstk = 4'b0100;
        step(1);
        check("pend_move", player_pos, 2);
        jstk = 4'b0000;
        step(4);
        check("stall_valid", shot_valid, 1);
        check("stall_spos",  shot_pos, 1);
        check("stall_scol",  shot_color, 10);
        shot_ready = 1'b1;
        step(1);
        shot_ready = 1'b0;
        check("xfer1_valid", shot_valid, 0);
        check("xfer1_row",   PlayerRow, exp_row(2, 11));

        // fire during cooldown is dropped, including just before the last tick
        jstk = 4'b0001;
        step(1);
        check("cool_fire0", shot_valid, 0);
        jstk = 4'b0000;
        step(1);
        repeat (3) pulse_tick();
        jstk = 4'b0001;
        step(1);
        check("cool_fire3", shot_valid, 0);
        jstk = 4'b0000;
        step(1);
        pulse_tick();
        jstk = 4'b0001;
        step(1);
        check("shot2_valid", shot_valid, 1);
        check("shot2_spos",  shot_pos, 2);
        check("shot2_scol",  shot_color, 11);
        jstk = 4'b0000;
        shot_ready = 1'b1;
        step(1);
        shot_ready = 1'b0;
        check("xfer2_row", PlayerRow, exp_row(2, 12));

        repeat (4) pulse_tick();
        jstk = 4'b0001;
        step(1);
        check("shot3_scol", shot_color, 12);
        jstk = 4'b0000;
        shot_ready = 1'b1;
        step(1);
        shot_ready = 1'b0;
        check("xfer3_row", PlayerRow, exp_row(2, 10));

        repeat (4) pulse_tick();
        jstk = 4'b0001;
        step(1);
        check("shot4_wrap", shot_color, 10);
        jstk = 4'b0000;
        shot_ready = 1'b1;
        step(1);
        shot_ready = 1'b0;
        check("xfer4_row", PlayerRow, exp_row(2, 11));

        // reset while pending, fire held through reset
        repeat (4) pulse_tick();
        jstk = 4'b0100;
        step(1);
        jstk = 4'b0001;
        step(1);
        check("shot5_spos", shot_pos, 3);
        check("shot5_scol", shot_color, 11);
        rst = 1'b1;
        step(1);
        check("prst_valid", shot_valid, 0);
        check("prst_pos",   player_pos, 1);
        check("prst_row",   PlayerRow, exp_row(1, 10));
        check("prst_spos",  shot_pos, 0);
        check("prst_scol",  shot_color, 10);
        rst = 1'b0;
        step(1);
        check("held_valid", shot_valid, 1);
        check("held_spos",  shot_pos, 1);
        check("held_scol",  shot_color, 10);
        jstk = 4'b0000;
        shot_ready = 1'b1;
        step(1);
        shot_ready = 1'b0;

        // freeze with en low while a shot is pending
        repeat (4) pulse_tick();
        jstk = 4'b0001;
        step(1);
        jstk = 4'b0000;
        step(1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            jstk = 4'(i * 5);
            tick = (i % 2 == 1);
            shot_ready = 1'b1;
            step(1);
        end
        check("frz_valid", shot_valid, 1);
        check("frz_pos",   player_pos, 1);
        check("frz_spos",  shot_pos, 1);
        check("frz_scol",  shot_color, 11);
        check("frz_row",   PlayerRow, exp_row(1, 11));
        jstk = 4'b0000;
        tick = 1'b0;
        shot_ready = 1'b0;
        en = 1'b1;
        step(1);
        check("unfrz_valid", shot_valid, 1);
        check("unfrz_pos",   player_pos, 1);
        shot_ready = 1'b1;
        step(1);
        shot_ready = 1'b0;
        check("unfrz_xfer", shot_valid, 0);
        check("unfrz_row",  PlayerRow, exp_row(1, 12));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
